order_sequencer: RTL
====================

Name: order_sequencer

Overview:
- Synthesizable layer-order controller for the conv accelerator core.
- Fetches each 32-word layer order record from an on-chip order RAM and latches its 18 used fields onto a configuration bus.
- Pulses calculate_start, waits for the conv datapath's calculate_finish rising edge, then advances to the next order.
- Stops on an END order (opcode 0) or on address exhaustion.

Parameters:
- ORDER_DEPTH, 128, number of order records in order RAM.
- ADDR_W, 7, order index width (log2 ORDER_DEPTH).
- START_LAYER, 0, order index loaded at reset and on each task_start.
- FIELD_NUM, 18, words fetched per record (words 0..17; 18..31 never read).
- RD_LAT, 1, order RAM read latency in cycles (1..3).

Ports:
- system_clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- task_start  in  1  one-cycle pulse; starts a program from START_LAYER.
- ord_rd_en  out  1  order RAM read enable.
- ord_rd_addr  out  ADDR_W+5  word address = {order_idx, word_idx[4:0]}.
- ord_rd_data  in  32  read data, valid exactly RD_LAT cycles after ord_rd_en.
- calculate_start  out  1  one-cycle pulse: cfg_bus is valid, datapath may start.
- calculate_finish  in  1  level from datapath; its rising edge ends the layer.
- cfg_bus  out  FIELD_NUM*32  word k at bits [32k+:32]; held stable from calculate_start until the next FETCH.
- order_idx  out  ADDR_W  index of the current or last order.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on program end.
- overrun  out  1  sticky; set when order_idx wraps without an END order; cleared by task_start.

Behaviour:
- Reset values: all outputs 0; order_idx = START_LAYER; state IDLE; finish edge register 0.
- States: IDLE, FETCH, DRAIN, DECODE, ISSUE, RUN.
- IDLE: on task_start, load order_idx = START_LAYER, clear overrun, go to FETCH. task_start in any other state is ignored.
- FETCH:
  - ord_rd_en = 1 for FIELD_NUM consecutive cycles, word_idx 0..FIELD_NUM-1.
  - Go to DRAIN after word_idx = FIELD_NUM-1 is issued.
- Capture: an RD_LAT-deep valid/word_idx shift pipe writes ord_rd_data into cfg_bus word word_idx.
- DRAIN: wait until the pipe is empty, then go to DECODE.
- DECODE (1 cycle):
  - If cfg_bus word0[2:0] == 0 (END): pulse done, go to IDLE; calculate_start is not issued.
  - Otherwise go to ISSUE.
- ISSUE: calculate_start = 1 for this cycle only, then go to RUN.
- RUN:
  - fin_edge = calculate_finish & ~finish_r, where finish_r is a 1-cycle register.
  - On fin_edge:
    - If order_idx == ORDER_DEPTH-1: set overrun, pulse done, go to IDLE.
    - Otherwise order_idx += 1 and go to FETCH.
  - A finish level already high on entry to RUN does not count; only a new rising edge ends the layer.
- Latency: task_start sampled at cycle T gives first ord_rd_en at T+1 and calculate_start at T+FIELD_NUM+RD_LAT+3 (T+22 at defaults).
- Inter-layer gap: fin_edge at cycle F gives the next calculate_start at F+FIELD_NUM+RD_LAT+3.
- Boundaries:
  - rst_n low mid-fetch or mid-run: immediate return to reset values; no done pulse.
  - calculate_finish pulses outside RUN are ignored. finish_r still tracks the input, so a level held across states does not create a false edge later.
  - ord_rd_addr upper bits equal order_idx throughout FETCH.

Decomposition:
- Package order_pkg holds:
  - FIELD_NUM and field word indices: ORDER=0, FEAT_IN_BASE=1, FEAT_IN_PATCH=2, FEAT_OUT_PATCH=3, DOUBLE_PATCH=4, PATCH_NUM=5, ROW=6, COL=7, W_QUANT=8, IN_QUANT=9, OUT_QUANT=10, STRIDE=11, RET_ADDR=12, RET_PATCH=13, PADDING=14, W_LEN=15, ACTIVATE=16, ID=17.
  - OP_END = 3'd0.
  - The state enumeration.
- One sub-module, order_field_unpack: combinational slicer from cfg_bus to the named, width-truncated conv parameter outputs, used by the datapath top.

Test Plan:
- RAM holds order0 opcode 1, id 0xA5, and order1 opcode 0; task_start at cycle 10 -> calculate_start at cycle 32, cfg word17 = 0x000000A5. Drive finish high at 40 -> done at cycle 61, calculate_start not issued, busy low.
- Three non-END orders followed by END; finish pulsed 5 cycles after each start -> exactly 3 calculate_start pulses, order_idx sequence 0,1,2, then done.
- calculate_finish held high from ISSUE onward -> no advance; drop and re-raise -> one advance.
- task_start repeated while in RUN -> ignored; order_idx and cfg_bus unchanged.
- ORDER_DEPTH = 4, no END order -> after the 4th finish edge, overrun = 1 and done pulses. Next task_start clears overrun.
- rst_n asserted mid-FETCH at word 7 -> all outputs 0 next edge, order_idx = START_LAYER; a later task_start runs cleanly.
- RD_LAT = 3 with distinct data per word -> cfg_bus word k == RAM word k for all k < 18.

Source files
------------

// File: rtl/order_pkg.sv
// Shared constants and types for the layer-order sequencer: record layout,
// opcode encoding and the controller state enumeration.
package order_pkg;

    localparam int WORD_W    = 32;
    localparam int FIELD_NUM = 18;

    // Word index of each used field inside a 32-word order record
    localparam int ORDER          = 0;
    localparam int FEAT_IN_BASE   = 1;
    localparam int FEAT_IN_PATCH  = 2;
    localparam int FEAT_OUT_PATCH = 3;
    localparam int DOUBLE_PATCH   = 4;
    localparam int PATCH_NUM      = 5;
    localparam int ROW            = 6;
    localparam int COL            = 7;
    localparam int W_QUANT        = 8;
    localparam int IN_QUANT       = 9;
    localparam int OUT_QUANT      = 10;
    localparam int STRIDE         = 11;
    localparam int RET_ADDR       = 12;
    localparam int RET_PATCH      = 13;
    localparam int PADDING        = 14;
    localparam int W_LEN          = 15;
    localparam int ACTIVATE       = 16;
    localparam int ID             = 17;

    localparam logic [2:0] OP_END = 3'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        DECODE = 3'd3,
        ISSUE  = 3'd4,
        RUN    = 3'd5
    } state_t;

endpackage

// File: rtl/order_field_unpack.sv
// Combinational slicer: splits the latched order record into the named,
// width-truncated conv parameters consumed by the datapath.
module order_field_unpack
    import order_pkg::*;
(
    input  logic [FIELD_NUM*WORD_W-1:0] cfg_bus,
    output logic [2:0]                  opcode,
    output logic [31:0]                 feat_in_base,
    output logic [15:0]                 feat_in_patch,
    output logic [15:0]                 feat_out_patch,
    output logic                        double_patch,
    output logic [15:0]                 patch_num,
    output logic [15:0]                 row,
    output logic [15:0]                 col,
    output logic [7:0]                  w_quant,
    output logic [7:0]                  in_quant,
    output logic [7:0]                  out_quant,
    output logic [3:0]                  stride,
    output logic [31:0]                 ret_addr,
    output logic [15:0]                 ret_patch,
    output logic [3:0]                  padding,
    output logic [31:0]                 w_len,
    output logic [1:0]                  activate,
    output logic [7:0]                  id
);

    // Upper bits of the truncated words carry no meaning for the datapath
    logic unused_bits;

    assign opcode         = cfg_bus[ORDER*WORD_W          +: 3];
    assign feat_in_base   = cfg_bus[FEAT_IN_BASE*WORD_W   +: 32];
    assign feat_in_patch  = cfg_bus[FEAT_IN_PATCH*WORD_W  +: 16];
    assign feat_out_patch = cfg_bus[FEAT_OUT_PATCH*WORD_W +: 16];
    assign double_patch   = cfg_bus[DOUBLE_PATCH*WORD_W];
    assign patch_num      = cfg_bus[PATCH_NUM*WORD_W      +: 16];
    assign row            = cfg_bus[ROW*WORD_W            +: 16];
    assign col            = cfg_bus[COL*WORD_W            +: 16];
    assign w_quant        = cfg_bus[W_QUANT*WORD_W        +: 8];
    assign in_quant       = cfg_bus[IN_QUANT*WORD_W       +: 8];
    assign out_quant      = cfg_bus[OUT_QUANT*WORD_W      +: 8];
    assign stride         = cfg_bus[STRIDE*WORD_W         +: 4];
    assign ret_addr       = cfg_bus[RET_ADDR*WORD_W       +: 32];
    assign ret_patch      = cfg_bus[RET_PATCH*WORD_W      +: 16];
    assign padding        = cfg_bus[PADDING*WORD_W        +: 4];
    assign w_len          = cfg_bus[W_LEN*WORD_W          +: 32];
    assign activate       = cfg_bus[ACTIVATE*WORD_W       +: 2];
    assign id             = cfg_bus[ID*WORD_W             +: 8];

    assign unused_bits = ^{cfg_bus[ORDER*WORD_W+3          +: 29],
                           cfg_bus[FEAT_IN_PATCH*WORD_W+16  +: 16],
                           cfg_bus[FEAT_OUT_PATCH*WORD_W+16 +: 16],
                           cfg_bus[DOUBLE_PATCH*WORD_W+1    +: 31],
                           cfg_bus[PATCH_NUM*WORD_W+16      +: 16],
                           cfg_bus[ROW*WORD_W+16            +: 16],
                           cfg_bus[COL*WORD_W+16            +: 16],
                           cfg_bus[W_QUANT*WORD_W+8         +: 24],
                           cfg_bus[IN_QUANT*WORD_W+8        +: 24],
                           cfg_bus[OUT_QUANT*WORD_W+8       +: 24],
                           cfg_bus[STRIDE*WORD_W+4          +: 28],
                           cfg_bus[RET_PATCH*WORD_W+16      +: 16],
                           cfg_bus[PADDING*WORD_W+4         +: 28],
                           cfg_bus[ACTIVATE*WORD_W+2        +: 30],
                           cfg_bus[ID*WORD_W+8              +: 24]};

endmodule

// File: rtl/order_sequencer.sv
// Layer-order controller: fetches each order record from the order RAM,
// latches it on cfg_bus, launches the conv datapath and advances on the
// rising edge of calculate_finish until an END order or index exhaustion.
module order_sequencer #(
    parameter int ORDER_DEPTH = 128,
    parameter int ADDR_W      = 7,
    parameter int START_LAYER = 0,
    parameter int FIELD_NUM   = 18,
    parameter int RD_LAT      = 1
) (
    input  logic                    system_clk,
    input  logic                    rst_n,
    input  logic                    task_start,
    output logic                    ord_rd_en,
    output logic [ADDR_W+4:0]       ord_rd_addr,
    input  logic [31:0]             ord_rd_data,
    output logic                    calculate_start,
    input  logic                    calculate_finish,
    output logic [FIELD_NUM*32-1:0] cfg_bus,
    output logic [ADDR_W-1:0]       order_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    import order_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        word_idx;
    logic              finish_r;
    logic              fin_edge;
    logic              last_order;
    logic [RD_LAT-1:0] cap_vld_p;
    logic [4:0]        cap_idx_p [RD_LAT];

    assign fin_edge    = calculate_finish & ~finish_r;
    assign last_order  = (order_idx == ADDR_W'(ORDER_DEPTH - 1));
    assign ord_rd_en   = (state == FETCH);
    assign ord_rd_addr = ord_rd_en ? {order_idx, word_idx} : '0;
    assign busy        = (state != IDLE);

    // State register, word counter, order index, overrun flag and finish history
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_idx  <= '0;
            order_idx <= ADDR_W'(START_LAYER);
            overrun   <= 1'b0;
            finish_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Tracks the input in every state so a held level never looks like a new edge
            finish_r <= calculate_finish;
            word_idx <= (state == FETCH) ? word_idx + 5'd1 : 5'd0;
            if (state == IDLE && task_start) begin
                order_idx <= ADDR_W'(START_LAYER);
                overrun   <= 1'b0;
            end
            if (state == RUN && fin_edge) begin
                if (last_order) begin
                    overrun <= 1'b1;
                end else begin
                    order_idx <= order_idx + ADDR_W'(1);
                end
            end
        end
    end

    // Read-valid pipe matching the RAM latency
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_p <= '0;
        end else begin
            cap_vld_p[0] <= ord_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                cap_vld_p[i] <= cap_vld_p[i-1];
            end
        end
    end

    // Word-index pipe travelling alongside the valid bits
    always_ff @(posedge system_clk) begin
        cap_idx_p[0] <= word_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            cap_idx_p[i] <= cap_idx_p[i-1];
        end
    end

    // Capture returning RAM words into their slot of the configuration bus
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_bus <= '0;
        end else if (cap_vld_p[RD_LAT-1]) begin
            for (int k = 0; k < FIELD_NUM; k++) begin
                if (cap_idx_p[RD_LAT-1] == 5'(k)) begin
                    cfg_bus[k*32 +: 32] <= ord_rd_data;
                end
            end
        end
    end

    // Next-state logic with the start and done pulses
    always_comb begin
        state_nxt       = state;
        calculate_start = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                if (task_start) state_nxt = FETCH;
            end
            FETCH: begin
                if (word_idx == 5'(FIELD_NUM - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (cap_vld_p == '0) state_nxt = DECODE;
            end
            DECODE: begin
                if (cfg_bus[ORDER*32 +: 3] == OP_END) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                calculate_start = 1'b1;
                state_nxt       = RUN;
            end
            RUN: begin
                if (fin_edge) begin
                    done      = last_order;
                    state_nxt = last_order ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
